// File: rtl/fib_checker_pkg.sv
// Shared definitions for the Fibonacci stream checker: state encoding,
// default widths and the restart-state helper.
package fib_checker_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int COUNT_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_EXP0  = 3'd0,
        ST_EXP1  = 3'd1,
        ST_SEED0 = 3'd2,
        ST_SEED1 = 3'd3,
        ST_TRACK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Where the checker starts after reset or clr.
    function automatic state_e init_state(input bit seed_any);
        return seed_any ? ST_SEED0 : ST_EXP0;
    endfunction

endpackage

// File: rtl/fib_checker_sat_counter.sv
// Up-counter with enable and synchronous clear that holds at its
// all-ones maximum instead of wrapping.
module fib_checker_sat_counter
    import fib_checker_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step up until saturated.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register; reset comes in through clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/fib_checker.sv
// Receive-side checker for a Fibonacci term stream. Tracks the expected
// (prev, cur) pair, judges each accepted term and reports match/mismatch
// pulses, a sticky error flag, a saturating count of correct terms and the
// value expected next.
module fib_checker
    import fib_checker_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit WRAP_MODE = 1'b1,
    parameter bit SEED_ANY  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   match,
    output logic                   mismatch,
    output logic                   err_flag,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] term_count,
    output logic [WIDTH-1:0]       exp_next
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] exp_next_q, exp_next_d;
    logic             match_q, match_d;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             restart;
    logic             transfer;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign restart  = reset | clr;
    // Ready depends only on clr and registered state, never on in_valid.
    assign in_ready = !clr && (state_q != ST_DONE);
    assign transfer = in_valid && in_ready;

    // One extra bit on the pair sum exposes the carry-out for the no-wrap mode.
    assign sum_full = {1'b0, prev_q} + {1'b0, cur_q};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];

    // Next-state, pair update and term judgement for one accepted term.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        exp_next_d = exp_next_q;
        err_d      = err_q;
        done_d     = done_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;

        if (restart) begin
            state_d    = init_state(SEED_ANY);
            prev_d     = '0;
            cur_d      = '0;
            exp_next_d = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end else if (transfer) begin
            case (state_q)
                ST_EXP0: begin
                    if (in_data == '0) begin
                        prev_d  = '0;
                        state_d = ST_EXP1;
                        match_d = 1'b1;
                    end else begin
                        mismatch_d = 1'b1;
                    end
                end
                ST_EXP1: begin
                    if (in_data == WIDTH'(1)) begin
                        cur_d   = WIDTH'(1);
                        state_d = ST_TRACK;
                        match_d = 1'b1;
                    end else begin
                        mismatch_d = 1'b1;
                    end
                end
                ST_SEED0: begin
                    prev_d  = in_data;
                    state_d = ST_SEED1;
                    match_d = 1'b1;
                end
                ST_SEED1: begin
                    cur_d   = in_data;
                    state_d = ST_TRACK;
                    match_d = 1'b1;
                end
                ST_TRACK: begin
                    // The pair follows the true sequence even when the term is
                    // wrong, so later terms are judged without resynchronising.
                    prev_d = cur_q;
                    cur_d  = sum;
                    if (in_data == sum) begin
                        match_d = 1'b1;
                    end else begin
                        mismatch_d = 1'b1;
                    end
                    if (carry && !WRAP_MODE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            if (mismatch_d) begin
                err_d = 1'b1;
            end
            exp_next_d = prev_d + cur_d;
        end
    end

    // State, pair and registered outputs.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        prev_q     <= prev_d;
        cur_q      <= cur_d;
        exp_next_q <= exp_next_d;
        match_q    <= match_d;
        mismatch_q <= mismatch_d;
        err_q      <= err_d;
        done_q     <= done_d;
    end

    fib_checker_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_term_count (
        .clk    (clk),
        .clear  (restart),
        .enable (match_d),
        .count  (term_count)
    );

    assign match    = match_q;
    assign mismatch = mismatch_q;
    assign err_flag = err_q;
    assign done     = done_q;
    assign exp_next = exp_next_q;

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: three configurations driven by one shared stream
// (wrap/start-0,1; no-wrap/start-0,1; wrap/seed-any), each judged against a
// position-based model of the Fibonacci rules.
module tb_fib_checker;

    localparam int N = 3;
    localparam bit CFG_WRAP [N] = '{1'b1, 1'b0, 1'b1};
    localparam bit CFG_SEED [N] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic [N-1:0] rdy, mat, mis, err, dn;
    logic [7:0]   cnt  [N];
    logic [7:0]   expn [N];

    int total = 0;
    int bad   = 0;

    // Model: number of accepted positions, true pair, flags, expected pulses.
    int m_pos [N];
    int m_p   [N];
    int m_c   [N];
    int m_err [N];
    int m_done[N];
    int m_cnt [N];
    int m_mat [N];
    int m_mis [N];

    always #5 clk = ~clk;

    fib_checker #(.WIDTH(8), .WRAP_MODE(1'b1), .SEED_ANY(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .match(mat[0]), .mismatch(mis[0]), .err_flag(err[0]),
        .done(dn[0]), .term_count(cnt[0]), .exp_next(expn[0]));

    fib_checker #(.WIDTH(8), .WRAP_MODE(1'b0), .SEED_ANY(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .match(mat[1]), .mismatch(mis[1]), .err_flag(err[1]),
        .done(dn[1]), .term_count(cnt[1]), .exp_next(expn[1]));

    fib_checker #(.WIDTH(8), .WRAP_MODE(1'b1), .SEED_ANY(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[2]), .match(mat[2]), .mismatch(mis[2]), .err_flag(err[2]),
        .done(dn[2]), .term_count(cnt[2]), .exp_next(expn[2]));

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Value the sequence requires at the model's current position.
    function automatic int want_term(input int i);
        if (m_pos[i] == 0) return 0;
        if (m_pos[i] == 1) return 1;
        return (m_p[i] + m_c[i]) % 256;
    endfunction

    task automatic model_step(input int i, input bit v, input int d, input bit c, input bit r);
        bit ok;
        int s;
        m_mat[i] = 0;
        m_mis[i] = 0;
        if (r || c) begin
            m_pos[i] = 0; m_p[i] = 0; m_c[i] = 0;
            m_err[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end else if (v && m_done[i] == 0) begin
            if (m_pos[i] < 2) begin
                ok = CFG_SEED[i] || (d == m_pos[i]);
                if (ok) begin
                    if (m_pos[i] == 0) m_p[i] = d; else m_c[i] = d;
                    m_pos[i]++;
                end
            end else begin
                s = m_p[i] + m_c[i];
                ok = (d == s % 256);
                m_p[i] = m_c[i];
                m_c[i] = s % 256;
                if (s >= 256 && !CFG_WRAP[i]) m_done[i] = 1;
            end
            if (ok) begin
                m_mat[i] = 1;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else begin
                m_mis[i] = 1;
                m_err[i] = 1;
            end
        end
    endtask

    // Drive one cycle, check ready before the edge and all outputs after it.
    task automatic step(input bit v, input int d, input bit c, input bit r);
        in_valid = v;
        in_data  = 8'(d);
        clr      = c;
        reset    = r;
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("in_ready[%0d]", i), int'(rdy[i]), int'(!c && m_done[i] == 0));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            model_step(i, v, d, c, r);
            check($sformatf("match[%0d]", i), int'(mat[i]), m_mat[i]);
            check($sformatf("mismatch[%0d]", i), int'(mis[i]), m_mis[i]);
            check($sformatf("err_flag[%0d]", i), int'(err[i]), m_err[i]);
            check($sformatf("done[%0d]", i), int'(dn[i]), m_done[i]);
            check($sformatf("term_count[%0d]", i), int'(cnt[i]), m_cnt[i]);
            if (m_pos[i] >= 2 && m_done[i] == 0)
                check($sformatf("exp_next[%0d]", i), int'(expn[i]), (m_p[i] + m_c[i]) % 256);
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic send_list(input int vals[$]);
        foreach (vals[k]) step(1'b1, vals[k], 1'b0, 1'b0);
    endtask

    initial begin
        int a, b, t;
        for (int i = 0; i < N; i++) model_step(i, 1'b0, 0, 1'b0, 1'b1);

        // Reset state.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        check("reset_exp_next", int'(expn[0]), 0);

        // Clean stream.
        send_list('{0, 1, 1, 2, 3, 5, 8, 13});
        check("t1_count", int'(cnt[0]), 8);
        check("t1_exp_next", int'(expn[0]), 21);
        check("t1_err", int'(err[0]), 0);

        // One wrong term; pair advances on the true value.
        step(1'b0, 0, 1'b1, 1'b0);
        send_list('{0, 1, 1, 2, 4, 5});
        check("t2_count", int'(cnt[0]), 5);
        check("t2_err", int'(err[0]), 1);
        step(1'b0, 0, 1'b0, 1'b0);
        check("t2_err_sticky", int'(err[0]), 1);

        // Full 8-bit run into the overflow: wraps in one config, ends in the other.
        step(1'b0, 0, 1'b1, 1'b0);
        a = 0; b = 1;
        send_list('{0, 1});
        while (a + b <= 233) begin
            t = a + b; a = b; b = t;
            step(1'b1, t, 1'b0, 1'b0);
        end
        send_list('{121, 98});
        check("t4_done", int'(dn[1]), 1);
        check("t4_ready", int'(rdy[1]), 0);
        check("t3_err", int'(err[0]), 0);
        send_list('{219, 61});

        // Seeded start, then clr with a term in flight.
        step(1'b0, 0, 1'b1, 1'b0);
        send_list('{7, 4, 11, 15});
        check("t5_count", int'(cnt[2]), 4);
        step(1'b1, 26, 1'b1, 1'b0);
        send_list('{26, 5, 31});
        check("t5_count_after_clr", int'(cnt[2]), 3);

        // Reset mid-stream with valid held high.
        step(1'b0, 0, 1'b1, 1'b0);
        send_list('{0, 1, 1, 2, 3});
        step(1'b1, 5, 1'b0, 1'b1);
        check("t6_match", int'(mat[0]), 0);
        check("t6_count", int'(cnt[0]), 0);
        send_list('{0, 1});

        // Long correct run to saturate term_count.
        step(1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) step(1'b1, want_term(0), 1'b0, 1'b0);
        check("sat_count", int'(cnt[0]), 255);

        // Random mix of correct terms, wrong terms, idle cycles and restarts.
        for (int k = 0; k < 600; k++) begin
            bit v, c, r;
            int d;
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(63) == 0);
            r = ($urandom_range(127) == 0);
            d = ($urandom_range(4) == 0) ? int'($urandom_range(255)) : want_term(0);
            step(v, d, c, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
